// File: rtl/iir_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : iir_stream_ctrl
//  Purpose  : Run controller for a streaming IIR filter. It discards the
//             settling transient, then captures NUM_SAMPLES SOS outputs into a
//             valid/ready output register.
//  Options  : IIR_CTRL_SKID_EN adds a one-entry skid buffer behind data_out.
//  Revision : 1.0 - initial release
// ============================================================================
module iir_stream_ctrl #(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 11,
    parameter int NUM_SAMPLES   = 2048,
    parameter int SETTLE_CYCLES = 237
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              data_in_valid,
    input  logic              sos_out_valid,
    input  logic [DATA_W-1:0] sos_out_data,
    input  logic              data_out_ready,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] addr,
    output logic              data_out_valid,
    output logic              stable_out,
    output logic              filter_done,
    output logic              overrun
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);
    localparam logic [SET_W-1:0] SETTLE_MAX  = SET_W'(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam bit               NO_SETTLE   = (SETTLE_CYCLES == 0);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FIRST = 3'd1,
        S_SETTLE     = 3'd2,
        S_RUN        = 3'd3,
        S_DRAIN      = 3'd4
    } state_t;

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [DATA_W-1:0]   data_q,       data_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic                valid_q,      valid_d;
    logic                stable_q,     stable_d;
    logic                done_q,       done_d;
    logic                overrun_q,    overrun_d;
`ifdef IIR_CTRL_SKID_EN
    logic                skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0]   skid_data_q,  skid_data_d;
    logic [ADDR_W-1:0]   skid_addr_q,  skid_addr_d;
`endif

    logic w_handshake;
    logic w_accept;
    logic w_empty_next;

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        settle_cnt_d = settle_cnt_q;
        data_d       = data_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        stable_d     = stable_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q;
        w_accept     = 1'b0;
        w_handshake  = valid_q && data_out_ready;
`ifdef IIR_CTRL_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_addr_d  = skid_addr_q;
        w_empty_next = !skid_valid_q && (!valid_q || w_handshake);
`else
        w_empty_next = !valid_q || w_handshake;
`endif

        if (w_handshake) begin
            valid_d = 1'b0;
        end
`ifdef IIR_CTRL_SKID_EN
        // The skid entry always refills data_out first so sample order is kept.
        if (w_handshake && skid_valid_q) begin
            data_d       = skid_data_q;
            addr_d       = skid_addr_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d      = S_WAIT_FIRST;
                    sample_cnt_d = '0;
                    settle_cnt_d = '0;
                    stable_d     = 1'b0;
                    overrun_d    = 1'b0;
                end
            end
            S_WAIT_FIRST: begin
                if (data_in_valid) begin
                    if (NO_SETTLE) begin
                        state_d  = S_RUN;
                        stable_d = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (sos_out_valid) begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d      = S_RUN;
                        stable_d     = 1'b1;
                        settle_cnt_d = SETTLE_MAX;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SET_ONE;
                    end
                end
            end
            S_RUN: begin
                if (sos_out_valid) begin
`ifdef IIR_CTRL_SKID_EN
                    if (!valid_q || w_handshake) begin
                        w_accept = 1'b1;
                        if (skid_valid_q) begin
                            skid_valid_d = 1'b1;
                            skid_data_d  = sos_out_data;
                            skid_addr_d  = sample_cnt_q[ADDR_W-1:0];
                        end else begin
                            data_d  = sos_out_data;
                            addr_d  = sample_cnt_q[ADDR_W-1:0];
                            valid_d = 1'b1;
                        end
                    end else if (!skid_valid_q) begin
                        w_accept     = 1'b1;
                        skid_valid_d = 1'b1;
                        skid_data_d  = sos_out_data;
                        skid_addr_d  = sample_cnt_q[ADDR_W-1:0];
                    end else begin
                        overrun_d = 1'b1;
                    end
`else
                    if (!valid_q || w_handshake) begin
                        w_accept = 1'b1;
                        data_d   = sos_out_data;
                        addr_d   = sample_cnt_q[ADDR_W-1:0];
                        valid_d  = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
`endif
                    if (w_accept) begin
                        sample_cnt_d = sample_cnt_q + CNT_ONE;
                        if (sample_cnt_q == SAMPLE_LAST) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (w_empty_next) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    stable_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything and drops any pending output.
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            stable_d = 1'b0;
            done_d   = 1'b0;
`ifdef IIR_CTRL_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sample_cnt_q <= '0;
            settle_cnt_q <= '0;
            data_q       <= '0;
            addr_q       <= '0;
            valid_q      <= 1'b0;
            stable_q     <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef IIR_CTRL_SKID_EN
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_addr_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            stable_q     <= stable_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
`ifdef IIR_CTRL_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_addr_q  <= skid_addr_d;
`endif
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign data_out       = data_q;
    assign addr           = addr_q;
    assign data_out_valid = valid_q;
    assign stable_out     = stable_q;
    assign filter_done    = done_q;
    assign overrun        = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_iir_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iir_stream_ctrl
//  Purpose  : Directed self-checking bench for iir_stream_ctrl (N=8, settle=3,
//             plus a settle=0 instance sharing the same stimulus).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iir_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        data_in_valid = 1'b0;
    logic        sos_out_valid = 1'b0;
    logic [15:0] sos_out_data = '0;
    logic        data_out_ready = 1'b1;

    logic        busy, data_out_valid, stable_out, filter_done, overrun;
    logic [15:0] data_out;
    logic [10:0] addr;

    logic        z_busy, z_valid, z_stable, z_done, z_overrun;
    logic [15:0] z_data;
    logic [10:0] z_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    iir_stream_ctrl #(.DATA_W(16), .ADDR_W(11), .NUM_SAMPLES(8), .SETTLE_CYCLES(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .data_in_valid(data_in_valid), .sos_out_valid(sos_out_valid),
        .sos_out_data(sos_out_data), .data_out_ready(data_out_ready),
        .busy(busy), .data_out(data_out), .addr(addr),
        .data_out_valid(data_out_valid), .stable_out(stable_out),
        .filter_done(filter_done), .overrun(overrun)
    );

    iir_stream_ctrl #(.DATA_W(16), .ADDR_W(11), .NUM_SAMPLES(8), .SETTLE_CYCLES(0)) u_dut_nosettle (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .data_in_valid(data_in_valid), .sos_out_valid(sos_out_valid),
        .sos_out_data(sos_out_data), .data_out_ready(data_out_ready),
        .busy(z_busy), .data_out(z_data), .addr(z_addr),
        .data_out_valid(z_valid), .stable_out(z_stable),
        .filter_done(z_done), .overrun(z_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (filter_done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    {31'd0, busy},           32'd0);
        check({tag, "_data"},    {16'd0, data_out},       32'd0);
        check({tag, "_addr"},    {21'd0, addr},           32'd0);
        check({tag, "_valid"},   {31'd0, data_out_valid}, 32'd0);
        check({tag, "_stable"},  {31'd0, stable_out},     32'd0);
        check({tag, "_done"},    {31'd0, filter_done},    32'd0);
        check({tag, "_overrun"}, {31'd0, overrun},        32'd0);
    endtask

    task automatic enter_run(input logic [15:0] base);
        start = 1'b1;
        tick();
        start = 1'b0;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sos_out_valid = 1'b1;
            sos_out_data  = base + 16'(i);
            tick();
        end
        sos_out_valid = 1'b0;
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Nominal run: values 0..10, first three discarded by settling.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s1_busy_after_start", {31'd0, busy}, 32'd1);
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        for (int v = 0; v <= 10; v++) begin
            sos_out_valid = 1'b1;
            sos_out_data  = 16'(v);
            tick();
            if (v == 0) begin
                check("s0_first_data",  {16'd0, z_data},  32'd0);
                check("s0_first_addr",  {21'd0, z_addr},  32'd0);
                check("s0_first_valid", {31'd0, z_valid}, 32'd1);
            end
            if (v == 1) check("s1_stable_low", {31'd0, stable_out}, 32'd0);
            if (v == 2) check("s1_stable_high", {31'd0, stable_out}, 32'd1);
            if (v >= 3) begin
                check("s1_data",  {16'd0, data_out},       32'(v));
                check("s1_addr",  {21'd0, addr},           32'(v - 3));
                check("s1_valid", {31'd0, data_out_valid}, 32'd1);
            end
        end
        sos_out_valid = 1'b0;
        tick();
        check("s1_done_pulse", {31'd0, filter_done},    32'd1);
        check("s1_busy_fall",  {31'd0, busy},           32'd0);
        check("s1_valid_clr",  {31'd0, data_out_valid}, 32'd0);
        check("s1_stable_clr", {31'd0, stable_out},     32'd0);
        tick();
        check("s1_done_low",  {31'd0, filter_done}, 32'd0);
        check("s1_done_once", 32'(done_cnt),        32'd1);

        // Output stall: ready low for 4 cycles with a sample every cycle.
        enter_run(16'd100);
        data_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sos_out_valid = 1'b1;
            sos_out_data  = 16'(i);
            tick();
            if (i == 0) begin
                check("s3_first_data", {16'd0, data_out}, 32'd0);
                check("s3_first_addr", {21'd0, addr},     32'd0);
            end
        end
        check("s3_hold_data",  {16'd0, data_out},       32'd0);
        check("s3_hold_addr",  {21'd0, addr},           32'd0);
        check("s3_hold_valid", {31'd0, data_out_valid}, 32'd1);
        check("s3_overrun",    {31'd0, overrun},        32'd1);
        data_out_ready = 1'b1;
        sos_out_data   = 16'd4;
        tick();
`ifdef IIR_CTRL_SKID_EN
        check("s3_resume_data", {16'd0, data_out}, 32'd1);
        check("s3_resume_addr", {21'd0, addr},     32'd1);
`else
        check("s3_resume_data", {16'd0, data_out}, 32'd4);
        check("s3_resume_addr", {21'd0, addr},     32'd1);
`endif
        sos_out_data = 16'd5;
        tick();
`ifdef IIR_CTRL_SKID_EN
        check("s3_next_data", {16'd0, data_out}, 32'd4);
        check("s3_next_addr", {21'd0, addr},     32'd2);
`else
        check("s3_next_data", {16'd0, data_out}, 32'd5);
        check("s3_next_addr", {21'd0, addr},     32'd2);
`endif
        sos_out_valid = 1'b0;
        tick();
`ifdef IIR_CTRL_SKID_EN
        check("s3_skid_data", {16'd0, data_out},       32'd5);
        check("s3_skid_addr", {21'd0, addr},           32'd3);
`else
        check("s3_empty",     {31'd0, data_out_valid}, 32'd0);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("s3_abort_busy",  {31'd0, busy},           32'd0);
        check("s3_abort_valid", {31'd0, data_out_valid}, 32'd0);

        // Abort together with start while settling.
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s4_overrun_clr", {31'd0, overrun}, 32'd0);
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        sos_out_valid = 1'b1;
        sos_out_data  = 16'd77;
        tick();
        sos_out_valid = 1'b0;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("s4_abort_busy",   {31'd0, busy},        32'd0);
        check("s4_abort_stable", {31'd0, stable_out},  32'd0);
        check("s4_abort_done",   {31'd0, filter_done}, 32'd0);
        tick();
        check("s4_start_ignored", {31'd0, busy}, 32'd0);
        enter_run(16'd200);
        for (int k = 0; k < 8; k++) begin
            sos_out_valid = 1'b1;
            sos_out_data  = 16'(20 + k);
            tick();
            check("s4_data", {16'd0, data_out}, 32'(20 + k));
            check("s4_addr", {21'd0, addr},     32'(k));
        end
        sos_out_valid = 1'b0;
        tick();
        check("s4_done_pulse", {31'd0, filter_done}, 32'd1);
        tick();
        check("s4_done_count", 32'(done_cnt), 32'd1);

        // Asynchronous reset in the middle of a run.
        enter_run(16'd300);
        sos_out_valid = 1'b1;
        sos_out_data  = 16'd50;
        tick();
        sos_out_data  = 16'd51;
        tick();
        sos_out_valid = 1'b0;
        check("s5_pre_valid", {31'd0, data_out_valid}, 32'd1);
        check("s5_pre_addr",  {21'd0, addr},           32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("s5_async");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("s5_idle_busy", {31'd0, busy}, 32'd0);
        enter_run(16'd400);
        sos_out_valid = 1'b1;
        sos_out_data  = 16'd60;
        tick();
        sos_out_valid = 1'b0;
        check("s5_rerun_data", {16'd0, data_out}, 32'd60);
        check("s5_rerun_addr", {21'd0, addr},     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
